fc_layer_engine: RTL and testbench

Parametrised fully-connected layer sequencer that replaces the hard-wired hidden/output sequencing inside `snn_core`. One `start` runs `N_OUT` neurons. Each neuron takes the dot product of `N_IN` inputs with a weight row, saturates it, passes it through an activation LUT, and writes the result to an output RAM. An optional argmax stage tracks the winning neuron, so a classifier layer produces its `digit` directly. Two instances chained through a shared RAM form the full network.

---
 rtl/fc_layer_engine_pkg.sv | 40 ++++
 rtl/fc_layer_engine_mac.sv | 45 ++++
 rtl/fc_layer_engine.sv | 174 +++++++++++++++++
 tb/tb_fc_layer_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_layer_engine_pkg.sv
// fc_pkg: shared types and arithmetic helpers for the fully-connected layer engine.
// The helpers work on a 64-bit signed carrier so that one definition serves every
// parameterisation. Callers size-cast the result back to their own width.
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    ACT,
    WRITE,
    DONE
  } fc_state_t;

  localparam int FC_XW = 64;
  typedef logic signed [FC_XW-1:0] fc_wide_t;

  // Clamp v to the signed range of a w-bit two's complement value.
  function automatic fc_wide_t fc_sat(input fc_wide_t v, input int w);
    fc_wide_t hi;
    fc_wide_t lo;
    hi = (fc_wide_t'(1) <<< (w - 1)) - fc_wide_t'(1);
    lo = -hi - fc_wide_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Saturating add: the running sum pins at the w-bit limits instead of wrapping.
  function automatic fc_wide_t fc_sat_add(input fc_wide_t a, input fc_wide_t b, input int w);
    return fc_sat(a + b, w);
  endfunction

  // LUT index: scale the accumulator down and clamp it to a signed aw-bit value.
  // Then offset it by half the table so that the most negative value reads entry 0.
  function automatic fc_wide_t fc_lut_index(input fc_wide_t acc, input int shift, input int aw);
    return fc_sat(acc >>> shift, aw) + (fc_wide_t'(1) <<< (aw - 1));
  endfunction

endpackage

// File: rtl/fc_layer_engine_mac.sv
// fc_mac: signed multiply-accumulate with a saturating accumulator.
// The unsigned input element is zero-extended before the multiply.
// acc_nxt exposes the value the accumulator takes at the next edge. The caller can
// then register a value derived from the final sum on the same edge as the last add.
module fc_mac
  import fc_pkg::*;
#(
  parameter int IN_W  = 1,
  parameter int W_W   = 8,
  parameter int ACC_W = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [IN_W-1:0]         a,
  input  logic signed [W_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc_nxt
);

  localparam int PW = IN_W + W_W + 1;

  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    b_ext;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;

  assign a_ext = $signed({{(PW - IN_W){1'b0}}, a});
  assign b_ext = {{(PW - W_W){b[W_W-1]}}, b};
  assign prod  = a_ext * b_ext;

  // Next accumulator value: clear wins over accumulate. Otherwise hold.
  always_comb begin
    acc_nxt = acc;
    if (clr) acc_nxt = '0;
    else if (en) acc_nxt = ACC_W'(fc_sat_add(fc_wide_t'(acc), fc_wide_t'(prod), ACC_W));
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else        acc <= acc_nxt;
  end

endmodule

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: sequences one fully-connected layer of N_OUT neurons over N_IN inputs.
// For each neuron, the engine streams the inputs and weights through fc_mac,
// looks up the activation, and writes the result to the output RAM.
// Each neuron takes N_IN MAC cycles followed by DRAIN, ACT and WRITE.
// All outputs come from registers. The output-RAM write is registered from the WRITE
// cycle, so the write strobe lands together with the q_lut value that was captured.
// Build option: define FC_ARGMAX_EN to compile in the winner tracker (max_idx/max_val).
// Without it, both outputs are tied to 0.
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 32,
  parameter int IN_W   = 1,
  parameter int W_W    = 8,
  parameter int ACC_W  = 25,
  parameter int LUT_AW = 11,
  parameter int ACT_W  = 8,
  parameter int SHIFT  = 6,
  localparam int IA_W  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int WA_W  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int OA_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [IA_W-1:0]       addr_in,
  input  logic [IN_W-1:0]       q_in,
  output logic [WA_W-1:0]       addr_w,
  input  logic signed [W_W-1:0] q_w,
  output logic [LUT_AW-1:0]     addr_lut,
  input  logic [ACT_W-1:0]      q_lut,
  output logic [OA_W-1:0]       addr_out,
  output logic [ACT_W-1:0]      d_out,
  output logic                  we_out,
  output logic [OA_W-1:0]       max_idx,
  output logic [ACT_W-1:0]      max_val
);

  fc_state_t               state;
  fc_state_t               state_nxt;
  logic [OA_W-1:0]         o_cnt;
  logic                    data_vld;
  logic                    start_acc;
  logic                    last_i;
  logic                    last_o;
  logic                    mac_clr;
  logic                    lut_ld;
  logic                    wr_ld;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [LUT_AW-1:0]       lut_nxt;

  assign start_acc = (state == IDLE) && start;
  // addr_in doubles as the input index i of the current neuron.
  assign last_i    = (addr_in == IA_W'(N_IN - 1));
  assign last_o    = (o_cnt == OA_W'(N_OUT - 1));

  fc_mac #(
    .IN_W  (IN_W),
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mac_clr),
    .en      (data_vld),
    .a       (q_in),
    .b       (q_w),
    .acc_nxt (acc_nxt)
  );

  // The LUT address is formed from the sum that includes the final product.
  // This lets it be registered at the end of DRAIN and presented during ACT.
  assign lut_nxt = LUT_AW'(fc_lut_index(fc_wide_t'(acc_nxt), SHIFT, LUT_AW));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. start is honoured only in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (last_i) state_nxt = DRAIN;
      DRAIN:   state_nxt = ACT;
      ACT:     state_nxt = WRITE;
      WRITE:   state_nxt = last_o ? DONE : MAC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state control strobes. Clearing in WRITE readies the MAC for the next neuron.
  always_comb begin
    mac_clr = 1'b0;
    lut_ld  = 1'b0;
    wr_ld   = 1'b0;
    case (state)
      IDLE:    mac_clr = 1'b1;
      DRAIN:   lut_ld  = 1'b1;
      WRITE: begin
        wr_ld   = 1'b1;
        mac_clr = 1'b1;
      end
      default: ;
    endcase
  end

  // Address counters, status flags and the registered output-RAM write.
  // The weight address just steps by one through every MAC cycle. The row base
  // (o*N_IN) falls out naturally, and it stops on the last element of the last row
  // so that it stays inside the ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_in  <= '0;
      addr_w   <= '0;
      o_cnt    <= '0;
      data_vld <= 1'b0;
      addr_lut <= '0;
      addr_out <= '0;
      d_out    <= '0;
      we_out   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // RAM data is valid one cycle after a MAC-cycle address.
      data_vld <= (state == MAC);
      busy     <= (state_nxt != IDLE) && (state_nxt != DONE);
      done     <= (state_nxt == DONE);
      we_out   <= wr_ld;
      if (start_acc) begin
        addr_in <= '0;
        addr_w  <= '0;
        o_cnt   <= '0;
      end else if (state == MAC) begin
        addr_in <= last_i ? '0 : addr_in + 1'b1;
        if (!(last_i && last_o)) addr_w <= addr_w + 1'b1;
      end else if (wr_ld && !last_o) begin
        o_cnt <= o_cnt + 1'b1;
      end
      if (lut_ld) addr_lut <= lut_nxt;
      if (wr_ld) begin
        addr_out <= o_cnt;
        d_out    <= q_lut;
      end
    end
  end

`ifdef FC_ARGMAX_EN
  // Winner tracker. Neuron 0 always seeds it, and a later neuron must be strictly
  // greater to take over, so ties keep the lower index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_idx <= '0;
      max_val <= '0;
    end else if (start_acc) begin
      max_idx <= '0;
      max_val <= '0;
    end else if (wr_ld && ((o_cnt == '0) || (q_lut > max_val))) begin
      max_idx <= o_cnt;
      max_val <= q_lut;
    end
  end
`else
  assign max_idx = '0;
  assign max_val = '0;
`endif

endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine. Two instances share the same input and weight
// memories and the same start/reset signals:
//   A uses the reference geometry (ACC_W=12, SHIFT=0, LUT_AW=4).
//   B has a narrow accumulator (ACC_W=8, SHIFT=1, LUT_AW=5), so accumulator saturation
//   actually occurs.
// Both instances use an identity LUT.
module tb_fc_layer_engine;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int LAT   = N_OUT * (N_IN + 3);
  localparam int ACC_A = 12, SH_A = 0, AW_A = 4;
  localparam int ACC_B = 8,  SH_B = 1, AW_B = 5;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int dones_a = 0, dones_b = 0;
  int exp_mi_a, exp_mv_a, exp_mi_b, exp_mv_b;
  wr_t exp_a[$];
  wr_t exp_b[$];

  logic [0:0]        in_mem[N_IN];
  logic signed [7:0] w_mem[N_IN*N_OUT];

  logic              busy_a, done_a, we_a, busy_b, done_b, we_b;
  logic [1:0]        addr_in_a, addr_out_a, max_idx_a, addr_in_b, addr_out_b, max_idx_b;
  logic [3:0]        addr_w_a, addr_lut_a, addr_w_b;
  logic [4:0]        addr_lut_b;
  logic [0:0]        q_in_a, q_in_b;
  logic signed [7:0] q_w_a, q_w_b;
  logic [7:0]        q_lut_a, d_out_a, max_val_a, q_lut_b, d_out_b, max_val_b;

  fc_layer_engine #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(1), .W_W(8), .ACC_W(ACC_A),
    .LUT_AW(AW_A), .ACT_W(8), .SHIFT(SH_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a), .done(done_a),
    .addr_in(addr_in_a), .q_in(q_in_a), .addr_w(addr_w_a), .q_w(q_w_a),
    .addr_lut(addr_lut_a), .q_lut(q_lut_a), .addr_out(addr_out_a), .d_out(d_out_a),
    .we_out(we_a), .max_idx(max_idx_a), .max_val(max_val_a)
  );

  fc_layer_engine #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(1), .W_W(8), .ACC_W(ACC_B),
    .LUT_AW(AW_B), .ACT_W(8), .SHIFT(SH_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b), .done(done_b),
    .addr_in(addr_in_b), .q_in(q_in_b), .addr_w(addr_w_b), .q_w(q_w_b),
    .addr_lut(addr_lut_b), .q_lut(q_lut_b), .addr_out(addr_out_b), .d_out(d_out_b),
    .we_out(we_b), .max_idx(max_idx_b), .max_val(max_val_b)
  );

  // Synchronous one-cycle-latency memories, plus identity activation tables.
  always @(posedge clk) begin
    q_in_a  <= in_mem[addr_in_a];
    q_w_a   <= w_mem[addr_w_a];
    q_lut_a <= 8'(addr_lut_a);
    q_in_b  <= in_mem[addr_in_b];
    q_w_b   <= w_mem[addr_w_b];
    q_lut_b <= 8'(addr_lut_b);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clampw(input int v, input int w);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Reference neuron: a dot product that saturates at every step, then a scale and
  // clamp, then the offset into the identity table.
  function automatic int neuron_out(input int o, input int acc_w, input int sh, input int aw);
    int acc = 0;
    for (int i = 0; i < N_IN; i++)
      acc = clampw(acc + int'(in_mem[i]) * int'(w_mem[o*N_IN+i]), acc_w);
    return clampw(acc >>> sh, aw) + (1 << (aw - 1));
  endfunction

  task automatic predict();
    int va, vb;
    for (int o = 0; o < N_OUT; o++) begin
      va = neuron_out(o, ACC_A, SH_A, AW_A);
      vb = neuron_out(o, ACC_B, SH_B, AW_B);
      exp_a.push_back('{o, va});
      exp_b.push_back('{o, vb});
      if (o == 0 || va > exp_mv_a) begin exp_mi_a = o; exp_mv_a = va; end
      if (o == 0 || vb > exp_mv_b) begin exp_mi_b = o; exp_mv_b = vb; end
    end
`ifndef FC_ARGMAX_EN
    exp_mi_a = 0; exp_mv_a = 0; exp_mi_b = 0; exp_mv_b = 0;
`endif
  endtask

  // Monitor: check each write against the queue, and check every done pulse.
  always @(negedge clk) begin : mon
    wr_t e;
    if (we_a) begin
      if (exp_a.size() == 0) chk("wr_unexpected_a", int'(addr_out_a), -1);
      else begin
        e = exp_a.pop_front();
        chk("wr_addr_a", int'(addr_out_a), e.addr);
        chk("wr_data_a", int'(d_out_a), e.data);
      end
    end
    if (we_b) begin
      if (exp_b.size() == 0) chk("wr_unexpected_b", int'(addr_out_b), -1);
      else begin
        e = exp_b.pop_front();
        chk("wr_addr_b", int'(addr_out_b), e.addr);
        chk("wr_data_b", int'(d_out_b), e.data);
      end
    end
    if (done_a) begin
      dones_a++;
      chk("latency_a", cyc - start_cyc, LAT);
      chk("pending_a", exp_a.size(), 0);
      chk("max_idx_a", int'(max_idx_a), exp_mi_a);
      chk("max_val_a", int'(max_val_a), exp_mv_a);
    end
    if (done_b) begin
      dones_b++;
      chk("pending_b", exp_b.size(), 0);
      chk("max_idx_b", int'(max_idx_b), exp_mi_b);
      chk("max_val_b", int'(max_val_b), exp_mv_b);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl_a"},  int'({busy_a, done_a, we_a}), 0);
    chk({tag, "_addr_a"}, int'({addr_in_a, addr_w_a, addr_lut_a, addr_out_a}), 0);
    chk({tag, "_data_a"}, int'({d_out_a, max_idx_a, max_val_a}), 0);
    chk({tag, "_ctl_b"},  int'({busy_b, done_b, we_b}), 0);
    chk({tag, "_addr_b"}, int'({addr_in_b, addr_w_b, addr_lut_b, addr_out_b}), 0);
    chk({tag, "_data_b"}, int'({d_out_b, max_idx_b, max_val_b}), 0);
  endtask

  // Mode 0: plain run.
  // Mode 1: an extra start pulse sampled at cycle 5.
  // Mode 2: start held during the DONE cycle.
  task automatic run_layer(input int mode);
    int n0a, n0b;
    predict();
    n0a = dones_a;
    n0b = dones_b;
    @(posedge clk); #1;
    chk("idle_busy", int'(busy_a), 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    chk("busy_rise", int'(busy_a), 1);
    for (int k = 0; k < LAT + 20 && dones_a == n0a; k++) begin
      @(posedge clk); #1;
      start = (mode == 1 && cyc - start_cyc == 4) || (mode == 2 && done_a);
    end
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("done_count_a", dones_a - n0a, 1);
    chk("done_count_b", dones_b - n0b, 1);
    chk("busy_after", int'(busy_a | busy_b), 0);
    chk("leftover_a", exp_a.size(), 0);
    chk("leftover_b", exp_b.size(), 0);
  endtask

  // Reset while neuron 1 is in its MAC phase.
  task automatic reset_mid();
    predict();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_cyc = cyc;
    while (cyc - start_cyc < N_IN + 5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    chk("midrst_writes_a", N_OUT - exp_a.size(), 1);
    exp_a.delete();
    exp_b.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_idle", int'({busy_a, we_a, busy_b, we_b}), 0);
  endtask

  task automatic load_basic();
    int bi[N_IN] = '{1, 1, 0, 1};
    int bw[N_IN*N_OUT] = '{1, 2, 3, 4, -1, -1, -1, -1, 5, 0, 0, 0};
    for (int i = 0; i < N_IN; i++) in_mem[i] = 1'(bi[i]);
    for (int k = 0; k < N_IN * N_OUT; k++) w_mem[k] = 8'(bw[k]);
  endtask

  task automatic load_fill(input int wv);
    for (int i = 0; i < N_IN; i++) in_mem[i] = 1'b1;
    for (int k = 0; k < N_IN * N_OUT; k++) w_mem[k] = 8'(wv);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    load_basic();
    run_layer(0);
    load_fill(127);
    run_layer(0);
    load_fill(-128);
    run_layer(0);
    load_basic();
    run_layer(1);
    run_layer(2);
    reset_mid();
    run_layer(0);
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N_IN; i++) in_mem[i] = 1'($urandom_range(0, 1));
      for (int k = 0; k < N_IN * N_OUT; k++) w_mem[k] = 8'($urandom_range(0, 255));
      run_layer(0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
